// File: rtl/fc_layer.sv
// Fully-connected layer core. Pops INPUT_SIZE words from a first-word-fall-through
// FIFO and multiply-accumulates each word against one weight per neuron for
// all neurons in parallel. It then adds the biases, rescales and saturates the
// results, and holds the output vector on a valid/ready handshake until it is
// accepted.
//
// Handshake rules:
// - Upstream: a pop happens in every cycle where ren_o = 1. ren_o is driven as
//   ~empty_i while accumulating.
// - Downstream: the vector transfers in the cycle where valid_o && ready_i.
//   While valid_o = 1, valid_o and data_o are held stable.
module fc_layer #(
  parameter int WORD_SIZE    = 16,
  parameter int FRAC_BITS    = 8,
  parameter int INPUT_SIZE   = 4,
  parameter int LAYER_HEIGHT = 5
) (
  input  logic                                                   clk_i,
  input  logic                                                   reset_n_i,
  input  logic                                                   empty_i,
  output logic                                                   ren_o,
  input  logic [WORD_SIZE-1:0]                                   data_i,
  input  logic [INPUT_SIZE-1:0][LAYER_HEIGHT-1:0][WORD_SIZE-1:0] weights_i,
  input  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]                 biases_i,
  output logic                                                   valid_o,
  input  logic                                                   ready_i,
  output logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]                 data_o,
  output logic [0:0]                                             state_o
);

  localparam int ACC_W  = 2 * WORD_SIZE + $clog2(INPUT_SIZE) + 1;
  localparam int PROD_W = 2 * WORD_SIZE;
  localparam int ADDR_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_DONE  = 1'b1;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    $signed({{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}});

  logic [0:0]              state_q, state_d;
  logic [ADDR_W-1:0]       in_addr_q, in_addr_d;
  logic signed [ACC_W-1:0] acc_q [LAYER_HEIGHT];
  logic signed [ACC_W-1:0] acc_d [LAYER_HEIGHT];

  logic signed [PROD_W-1:0] prod     [LAYER_HEIGHT];
  logic signed [ACC_W-1:0]  prod_ext [LAYER_HEIGHT];
  logic signed [ACC_W-1:0]  bias_ext [LAYER_HEIGHT];
  logic signed [ACC_W-1:0]  sum      [LAYER_HEIGHT];
  logic signed [ACC_W-1:0]  scaled   [LAYER_HEIGHT];

  logic pop;
  logic last_in;

  assign pop     = (state_q == S_ACCUM) && !empty_i;
  assign last_in = (in_addr_q == ADDR_W'(INPUT_SIZE - 1));
  assign ren_o   = pop;
  assign valid_o = (state_q == S_DONE);
  assign state_o = state_q;

  // Per-neuron datapath:
  // - full-precision product of the current word and this neuron's weight;
  // - bias aligned to the accumulator's binary point;
  // - floor rescale (arithmetic right shift).
  for (genvar n = 0; n < LAYER_HEIGHT; n++) begin : g_neuron
    assign prod[n]     = $signed(data_i) * $signed(weights_i[in_addr_q][n]);
    assign prod_ext[n] = $signed({{(ACC_W-PROD_W){prod[n][PROD_W-1]}}, prod[n]});
    assign bias_ext[n] = $signed({{(ACC_W-WORD_SIZE){biases_i[n][WORD_SIZE-1]}},
                                  biases_i[n]}) <<< FRAC_BITS;
    assign sum[n]      = acc_q[n] + bias_ext[n];
    assign scaled[n]   = sum[n] >>> FRAC_BITS;
  end

  // Next-state logic: accumulate on pops, and release the result on handshake.
  always_comb begin
    state_d   = state_q;
    in_addr_d = in_addr_q;
    acc_d     = acc_q;
    unique case (state_q)
      S_ACCUM: begin
        if (pop) begin
          for (int n = 0; n < LAYER_HEIGHT; n++) begin
            acc_d[n] = acc_q[n] + prod_ext[n];
          end
          if (last_in) begin
            in_addr_d = '0;
            state_d   = S_DONE;
          end else begin
            in_addr_d = in_addr_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        if (ready_i) begin
          for (int n = 0; n < LAYER_HEIGHT; n++) begin
            acc_d[n] = '0;
          end
          state_d = S_ACCUM;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  // State, input counter and accumulator registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_ACCUM;
      in_addr_q <= '0;
      for (int n = 0; n < LAYER_HEIGHT; n++) begin
        acc_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      in_addr_q <= in_addr_d;
      for (int n = 0; n < LAYER_HEIGHT; n++) begin
        acc_q[n] <= acc_d[n];
      end
    end
  end

  // Output vector: saturated results while valid, zero otherwise.
  always_comb begin
    data_o = '0;
    if (state_q == S_DONE) begin
      for (int n = 0; n < LAYER_HEIGHT; n++) begin
        if (scaled[n] > SAT_MAX) begin
          data_o[n] = SAT_MAX[WORD_SIZE-1:0];
        end else if (scaled[n] < SAT_MIN) begin
          data_o[n] = SAT_MIN[WORD_SIZE-1:0];
        end else begin
          data_o[n] = scaled[n][WORD_SIZE-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer.
// - A frame-level reference model holds the popped words in a queue.
// - When the frame is complete, the model computes each neuron's result with
//   64-bit integer arithmetic.
// - A single compare process checks ren_o, valid_o and data_o against the
//   model on every falling edge.
// - Directed frames carry hand-computed literal results.
module tb_fc_layer;

  localparam int W  = 16;
  localparam int FB = 8;
  localparam int IS = 4;
  localparam int LH = 5;

  logic                        clk;
  logic                        rst_n;
  logic                        empty;
  logic                        ren;
  logic [W-1:0]                data_in;
  logic [IS-1:0][LH-1:0][W-1:0] weights;
  logic [LH-1:0][W-1:0]        biases;
  logic                        valid;
  logic                        ready;
  logic [LH-1:0][W-1:0]        data_out;
  logic [0:0]                  state;

  int n_vec  = 0;
  int n_err  = 0;
  int dut_pops = 0;

  fc_layer #(.WORD_SIZE(W), .FRAC_BITS(FB), .INPUT_SIZE(IS), .LAYER_HEIGHT(LH)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .empty_i   (empty),
    .ren_o     (ren),
    .data_i    (data_in),
    .weights_i (weights),
    .biases_i  (biases),
    .valid_o   (valid),
    .ready_i   (ready),
    .data_o    (data_out),
    .state_o   (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] frame_q[$];
  bit           m_pending;

  function automatic logic [W-1:0] model_out(int n);
    longint s;
    s = 0;
    for (int k = 0; k < frame_q.size(); k++) begin
      s += longint'($signed(frame_q[k])) * longint'($signed(weights[k][n]));
    end
    s += longint'($signed(biases[n])) * (longint'(1) << FB);
    s = s >>> FB;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[W-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 1'b0;
      frame_q.delete();
    end else if (!m_pending) begin
      if (!empty) begin
        frame_q.push_back(data_in);
        if (frame_q.size() == IS) m_pending = 1'b1;
      end
    end else if (ready) begin
      m_pending = 1'b0;
      frame_q.delete();
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("ren", 64'(ren), 64'(!m_pending && !empty));
    chk("valid", 64'(valid), 64'(m_pending));
    for (int n = 0; n < LH; n++) begin
      chk("data", 64'(data_out[n]), m_pending ? 64'(model_out(n)) : 64'(0));
    end
    if (ren && !empty) dut_pops++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_weights(input logic [W-1:0] w);
    for (int k = 0; k < IS; k++)
      for (int n = 0; n < LH; n++)
        weights[k][n] = w;
  endtask

  // Offer IS words; with bubbles, one empty cycle precedes each word.
  task automatic run_frame(input logic [W-1:0] w, input bit bubbles, input int nwords);
    bit popped;
    for (int i = 0; i < nwords; i++) begin
      if (bubbles) begin
        empty = 1'b1;
        @(posedge clk); #2;
      end
      data_in = w;
      empty   = 1'b0;
      popped  = 1'b0;
      for (int c = 0; c < 50 && !popped; c++) begin
        @(negedge clk);
        popped = ren;
        @(posedge clk); #2;
      end
      if (!popped) chk("pop_timeout", 64'(0), 64'(1));
    end
    empty = 1'b1;
  endtask

  // Wait for valid_o, then check against literal results (neuron 2 may differ).
  task automatic check_frame(input logic [W-1:0] e_other, input logic [W-1:0] e2);
    bit seen;
    logic [W-1:0] e;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = valid;
    end
    chk("valid_timeout", 64'(seen), 64'(1));
    for (int n = 0; n < LH; n++) begin
      e = (n == 2) ? e2 : e_other;
      chk("lit_dut", 64'(data_out[n]), 64'(e));
      chk("lit_model", 64'(model_out(n)), 64'(e));
    end
  endtask

  task automatic async_reset_pulse();
    @(posedge clk); #3;
    empty = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_ren", 64'(ren), 64'(0));
    chk("rst_data", 64'(data_out), 64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [LH-1:0][W-1:0] held;
  int pops0;

  initial begin
    rst_n   = 1'b0;
    empty   = 1'b1;
    data_in = '0;
    ready   = 1'b1;
    biases  = '0;
    set_weights(16'h0080);
    #1;
    chk("init_valid", 64'(valid), 64'(0));
    chk("init_ren", 64'(ren), 64'(0));
    chk("init_data", 64'(data_out), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Asynchronous reset between edges
    async_reset_pulse();

    // Basic frame
    pops0 = dut_pops;
    run_frame(16'h0100, 1'b0, IS);
    check_frame(16'h0200, 16'h0200);
    chk("basic_pops", 64'(dut_pops - pops0), 64'(IS));

    // Bubbles and bias on neuron 2
    @(posedge clk); #2;
    biases[2] = 16'hFF00;
    pops0 = dut_pops;
    run_frame(16'h0100, 1'b1, IS);
    check_frame(16'h0200, 16'h0100);
    @(posedge clk); #2;
    chk("bubble_pops", 64'(dut_pops - pops0), 64'(IS));
    biases = '0;

    // Backpressure with a non-empty FIFO
    ready = 1'b0;
    run_frame(16'h0100, 1'b0, IS);
    check_frame(16'h0200, 16'h0200);
    held = data_out;
    @(posedge clk); #2;
    empty   = 1'b0;
    data_in = 16'h0100;
    repeat (10) begin
      @(negedge clk);
      chk("hold_data", 64'(data_out), 64'(held));
      chk("hold_ren", 64'(ren), 64'(0));
    end
    @(posedge clk); #2;
    ready = 1'b1;
    empty = 1'b1;
    @(posedge clk); #2;
    set_weights(16'h0100);
    run_frame(16'h0100, 1'b0, IS);
    check_frame(16'h0400, 16'h0400);

    // Saturation and rounding
    @(posedge clk); #2;
    set_weights(16'h7FFF);
    run_frame(16'h7FFF, 1'b0, IS);
    check_frame(16'h7FFF, 16'h7FFF);
    @(posedge clk); #2;
    set_weights(16'h8000);
    run_frame(16'h7FFF, 1'b0, IS);
    check_frame(16'h8000, 16'h8000);
    @(posedge clk); #2;
    set_weights(16'h0100);
    run_frame(16'hFF00, 1'b0, IS);
    check_frame(16'hFC00, 16'hFC00);
    @(posedge clk); #2;
    set_weights(16'h0001);
    run_frame(16'h0001, 1'b0, IS);
    check_frame(16'h0000, 16'h0000);

    // Reset mid-frame, then a clean basic frame
    @(posedge clk); #2;
    set_weights(16'h0080);
    run_frame(16'h7FFF, 1'b0, 2);
    async_reset_pulse();
    run_frame(16'h0100, 1'b0, IS);
    check_frame(16'h0200, 16'h0200);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fc_layer.md
# fc_layer

Fully-connected layer core that sits directly upstream of the fully-connected output serializer. It pops INPUT_SIZE signed fixed-point words one at a time from an input FIFO, multiply-accumulates each word against one weight per neuron for all LAYER_HEIGHT neurons in parallel, then adds the biases and rescales/saturates the results. It presents the full LAYER_HEIGHT-word vector on a valid/ready handshake to the serializer, and holds it there until the serializer accepts it.

## Interface

- WORD_SIZE, 16: width of data, weight and bias words; two's complement, fixed point.
- FRAC_BITS, 8: fractional bits of every word, so 1.0 = 2^FRAC_BITS.
- INPUT_SIZE, 4: number of input words per frame; must be ≥ 2.
- LAYER_HEIGHT, 5: number of neurons, which is also the number of output words.

- clk_i, input, 1: the single clock.
- reset_n_i, input, 1: asynchronous, active-low reset.
- empty_i, input, 1: the input FIFO is empty. data_i is valid whenever empty_i = 0 (first-word-fall-through FIFO).
- ren_o, output, 1: pop request to the input FIFO.
- data_i, input, WORD_SIZE: current input word.
- weights_i, input, [INPUT_SIZE-1:0][LAYER_HEIGHT-1:0][WORD_SIZE-1:0]: weight for input k, neuron n. Static during operation.
- biases_i, input, [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]: bias per neuron. Static during operation.
- valid_o, output, 1: the output vector is valid.
- ready_i, input, 1: the downstream stage accepts the vector.
- data_o, output, [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]: output vector.

## Operation

- There are two states:
  - eACCUM: reset state.
  - eDONE.
- Input counter in_addr runs 0..INPUT_SIZE-1.
- Each neuron n has a signed accumulator acc[n] of width ACC_W = 2*WORD_SIZE + $clog2(INPUT_SIZE) + 1.
- eACCUM behaviour:
  - ren_o = ~empty_i. This is a demanding handshake: a pop happens in every cycle where ren_o = 1.
  - On each pop: acc[n] += sext(data_i) * sext(weights_i[in_addr][n]) for all n, using a full-precision signed product, and in_addr increments.
  - On a pop with in_addr == INPUT_SIZE-1: go to eDONE and clear in_addr to 0.
  - ready_i is ignored in this state.
- eDONE behaviour:
  - ren_o = 0 and valid_o = 1.
  - data_o[n] = sat(floor((acc[n] + (sext(biases_i[n]) <<< FRAC_BITS)) / 2^FRAC_BITS)). The division is an arithmetic right shift, i.e. round toward -inf.
  - sat clamps to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
  - No ReLU is applied.
- Leaving eDONE: when valid_o && ready_i, clear every acc[n] to 0 and return to eACCUM.
- data_o = '0 whenever valid_o = 0.
- Frames never overlap: no input is popped while a result is pending.

## Timing

- Reset (reset_n_i low, asynchronous):
  - ps = eACCUM, in_addr = 0, acc = 0.
  - Outputs: valid_o = 0, data_o = 0. ren_o = ~empty_i, which is combinational from the state.
  - Release of reset is synchronized by the reset tree. The first pop can occur on the first clock edge after release.
- Throughput: with no bubbles and no backpressure, one pop per cycle.
  - valid_o rises on the clock edge that registers the INPUT_SIZE-th pop.
  - A frame takes INPUT_SIZE + 1 cycles (INPUT_SIZE pops + 1 handshake cycle).
- Handshake acceptance: if ready_i = 1 in the first cycle of valid_o, that single cycle completes the handshake. The next pop can then happen in the following cycle.
- Input bubbles (empty_i = 1): no pop, and in_addr and acc hold.
- Backpressure (ready_i = 0 in eDONE): valid_o and data_o are held stable indefinitely and ren_o stays 0.
- Reset mid-frame: partial accumulation is discarded. The next frame starts from in_addr = 0 and acc = 0.
- Boundary case: empty_i deasserting in the same cycle as the handshake has no effect in that cycle; the pop happens in the next cycle in eACCUM.

## Test plan

All scenarios use the default parameters (WORD_SIZE=16, FRAC_BITS=8, INPUT_SIZE=4, LAYER_HEIGHT=5).

- Reset check: assert reset_n_i with empty_i = 1, including asynchronously between clock edges -> valid_o = 0, ren_o = 0, data_o = 0 immediately.
- Basic frame: inputs 0x0100 ×4, all weights 0x0080, biases 0, ready_i = 1 -> ren_o high for 4 cycles. valid_o is high for exactly 1 cycle, on the cycle after the 4th pop, with every data_o[n] = 0x0200.
- Bubbles and bias: same data with empty_i toggling every cycle, and biases_i[2] = 0xFF00 -> exactly 4 pops total, data_o[2] = 0x0100, all other outputs = 0x0200.
- Backpressure: hold ready_i = 0 for 10 cycles in eDONE while the FIFO is non-empty -> valid_o and data_o are stable and ren_o = 0 throughout. After ready_i rises, the next frame of inputs 0x0100 with weights 0x0100 gives 0x0400, confirming the accumulator was cleared.
- Saturation: inputs 0x7FFF ×4 with weights 0x7FFF -> 0x7FFF. The same inputs with weights 0x8000 -> 0x8000. Inputs 0xFF00 ×4 with weights 0x0100 -> 0xFC00. Inputs 0x0001 with weights 0x0001 -> 0x0000.
- Reset mid-frame: pop 2 words of 0x7FFF, pulse reset_n_i low, then run the basic-frame stimulus -> 0x0200 on all neurons, with no residue from the aborted frame.
